// File: rtl/vec_mem_stage.sv
// Vector memory-stage sequencer: scatters 8-lane stores and gathers 8-lane loads
// through a single-port data memory, one lane per cycle, then presents a result bundle.
module vec_mem_stage #(
  parameter int N = 20,
  parameter int A = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0][N-1:0]   ALUResult,
  input  logic [7:0][N-1:0]   writeData,
  input  logic [3:0]          WA3,
  input  logic                RegWrite,
  input  logic                MemtoReg,
  input  logic                MemWrite,
  output logic                ready,
  output logic [A-1:0]        mem_addr,
  output logic [N-1:0]        mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [N-1:0]        mem_rdata,
  output logic                out_valid,
  output logic [7:0][N-1:0]   ALUResultO,
  output logic [7:0][N-1:0]   ReadDataO,
  output logic [3:0]          WA3O,
  output logic                RegWriteO,
  output logic                MemtoRegO
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, LDRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        lane_q, lane_d;
  logic [7:0][N-1:0] aluRes_q, aluRes_d;
  logic [7:0][N-1:0] wdata_q, wdata_d;
  logic [7:0][N-1:0] readData_q, readData_d;
  logic [3:0]        wa3_q, wa3_d;
  logic              regWrite_q, regWrite_d;
  logic              memtoReg_q, memtoReg_d;
  logic              outValid_q, outValid_d;
  logic [A-1:0]      memAddr_q, memAddr_d;
  logic [N-1:0]      memWdata_q, memWdata_d;
  logic              accept;
  logic [A-1:0]      laneAddr;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    aluRes_d   = aluRes_q;
    wdata_d    = wdata_q;
    readData_d = readData_q;
    wa3_d      = wa3_q;
    regWrite_d = regWrite_q;
    memtoReg_d = memtoReg_q;
    outValid_d = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ready      = (state_q == IDLE);
    accept     = in_valid && (state_q == IDLE);
    laneAddr   = aluRes_q[lane_q][A-1:0];
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = memAddr_q;
    mem_wdata  = memWdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          aluRes_d   = ALUResult;
          wdata_d    = writeData;
          wa3_d      = WA3;
          regWrite_d = RegWrite;
          memtoReg_d = MemtoReg;
          lane_d     = 3'd0;
          if (MemWrite) begin
            state_d    = STORE;
            readData_d = '0;
          end else if (MemtoReg) begin
            state_d = LOAD;
          end else begin
            outValid_d = 1'b1;
            readData_d = '0;
          end
        end
      end
      STORE: begin
        mem_we     = 1'b1;
        mem_addr   = laneAddr;
        mem_wdata  = wdata_q[lane_q];
        memAddr_d  = laneAddr;
        memWdata_d = wdata_q[lane_q];
        lane_d     = lane_q + 3'd1;
        if (lane_q == 3'd7) begin
          state_d    = DONE;
          outValid_d = 1'b1;
        end
      end
      LOAD: begin
        mem_re    = 1'b1;
        mem_addr  = laneAddr;
        memAddr_d = laneAddr;
        lane_d    = lane_q + 3'd1;
        // Read data trails the strobe by one cycle, so this cycle returns the previous lane.
        if (lane_q != 3'd0) readData_d[lane_q - 3'd1] = mem_rdata;
        if (lane_q == 3'd7) state_d = LDRAIN;
      end
      LDRAIN: begin
        readData_d[7] = mem_rdata;
        state_d       = DONE;
        outValid_d    = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_q     <= 3'd0;
      aluRes_q   <= '0;
      wdata_q    <= '0;
      readData_q <= '0;
      wa3_q      <= 4'd0;
      regWrite_q <= 1'b0;
      memtoReg_q <= 1'b0;
      outValid_q <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      aluRes_q   <= aluRes_d;
      wdata_q    <= wdata_d;
      readData_q <= readData_d;
      wa3_q      <= wa3_d;
      regWrite_q <= regWrite_d;
      memtoReg_q <= memtoReg_d;
      outValid_q <= outValid_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign out_valid  = outValid_q;
  assign ALUResultO = aluRes_q;
  assign ReadDataO  = readData_q;
  assign WA3O       = wa3_q;
  assign RegWriteO  = regWrite_q;
  assign MemtoRegO  = memtoReg_q;

endmodule
